// File: rtl/pmod_loopback_pkg.sv
// ============================================================================
// Module      : pmod_loopback_pkg
// Description : Shared types, constants and pattern ROM for the Pmod loopback
//               self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmod_loopback_pkg;

    localparam int NUM_VECTORS = 20;
    localparam int ERR_SAT     = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Walking one, walking zero, then the four solid/checkerboard patterns.
    function automatic logic [7:0] pattern_rom(input logic [4:0] idx);
        logic [7:0] pat;
        pat = 8'h00;
        if (idx < 5'd8) begin
            pat = 8'h01 << idx[2:0];
        end else if (idx < 5'd16) begin
            pat = ~(8'h01 << idx[2:0]);
        end else begin
            case (idx)
                5'd17:   pat = 8'hFF;
                5'd18:   pat = 8'h55;
                5'd19:   pat = 8'hAA;
                default: pat = 8'h00;
            endcase
        end
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a bus of quasi-static inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pmod_loopback_seq.sv
// ============================================================================
// Module      : pmod_loopback_seq
// Description : Drives a fixed pattern set onto JA, samples JB/JC after a
//               settle time and accumulates mismatch masks and bit-error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmod_loopback_seq
    import pmod_loopback_pkg::*;
#(
    parameter int SETTLE_CYCLES = 100,
    parameter bit JC_INVERT     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] jb_in,
    input  logic [7:0] jc_in,
    output logic [7:0] pattern_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] fail_mask_b,
    output logic [7:0] fail_mask_c,
    output logic [4:0] vec_idx
);

    localparam int              c_cnt_w       = $clog2(SETTLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [4:0]      c_last_idx    = 5'(NUM_VECTORS - 1);

    generate
        if (SETTLE_CYCLES < 3) begin : g_settle_min
            $error("SETTLE_CYCLES must be at least 3 to cover synchronizer latency");
        end
    endgenerate

    state_t             r_state, w_state_n;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
    logic [4:0]         r_idx, w_idx_n;
    logic [7:0]         r_pat, w_pat_n;
    logic [7:0]         r_mask_b, w_mask_b_n;
    logic [7:0]         r_mask_c, w_mask_c_n;
    logic [7:0]         r_err, w_err_n;

    logic [7:0] w_jb_sync;
    logic [7:0] w_jc_sync;
    logic [7:0] w_mism_b;
    logic [7:0] w_mism_c;
    logic [4:0] w_pop;
    logic [8:0] w_sum;

    sync_2ff #(.WIDTH(8)) u_sync_jb (
        .clk   (clk),
        .reset (reset),
        .d     (jb_in),
        .q     (w_jb_sync)
    );

    sync_2ff #(.WIDTH(8)) u_sync_jc (
        .clk   (clk),
        .reset (reset),
        .d     (jc_in),
        .q     (w_jc_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_pat    <= '0;
            r_mask_b <= '0;
            r_mask_c <= '0;
            r_err    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_pat    <= w_pat_n;
            r_mask_b <= w_mask_b_n;
            r_mask_c <= w_mask_c_n;
            r_err    <= w_err_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_idx_n    = r_idx;
        w_pat_n    = r_pat;
        w_mask_b_n = r_mask_b;
        w_mask_c_n = r_mask_c;
        w_err_n    = r_err;

        // r_pat still holds the vector under test throughout CHECK.
        w_mism_b = r_pat ^ w_jb_sync;
        w_mism_c = r_pat ^ w_jc_sync ^ {8{JC_INVERT}};
        w_pop    = '0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + 5'(w_mism_b[i]) + 5'(w_mism_c[i]);
        end
        w_sum = {1'b0, r_err} + {4'b0, w_pop};

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_n  = ST_DRIVE;
                    w_idx_n    = '0;
                    w_mask_b_n = '0;
                    w_mask_c_n = '0;
                    w_err_n    = '0;
                end
            end
            ST_DRIVE: begin
                w_pat_n   = pattern_rom(r_idx);
                w_cnt_n   = c_settle_load;
                w_state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_CHECK;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_CHECK: begin
                w_mask_b_n = r_mask_b | w_mism_b;
                w_mask_c_n = r_mask_c | w_mism_c;
                w_err_n    = (w_sum > 9'(ERR_SAT)) ? 8'(ERR_SAT) : w_sum[7:0];
                if (r_idx == c_last_idx) begin
                    w_state_n = ST_DONE;
                    w_pat_n   = 8'h00;
                end else begin
                    w_idx_n   = r_idx + 5'd1;
                    w_state_n = ST_DRIVE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_pat_n   = 8'h00;
            end
        endcase
    end

    assign pattern_out = r_pat;
    assign busy        = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done        = (r_state == ST_DONE);
    assign pass        = (r_state == ST_DONE) && (r_err == 8'd0);
    assign err_count   = {1'b0, r_err};
    assign fail_mask_b = r_mask_b;
    assign fail_mask_c = r_mask_c;
    assign vec_idx     = r_idx;

endmodule

`default_nettype wire
